// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes engine. A 128-bit state is accepted over a
// valid/ready handshake, substituted NUM_SBOX bytes per cycle through shared
// inverse S-box lanes, and returned over a second valid/ready handshake.

// Single-byte AES inverse S-box lookup.
module inv_sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);
    // Table index 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign result = TABLE[data];
endmodule

module inv_subbytes_seq #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NCHUNK = 16 / NUM_SBOX;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    // Only lane counts that tile the 16-byte state evenly are meaningful.
    generate
        if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
            NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
            $fatal(1, "inv_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Byte 0 of the state is the most significant byte, so index 0 maps to [127:120].
    logic [0:15][7:0] work;
    logic [3:0]       base;
    logic [7:0]       lane_in  [NUM_SBOX];
    logic [7:0]       lane_out [NUM_SBOX];

    // First byte of the chunk being substituted this cycle.
    assign base = 4'(int'(cnt) * NUM_SBOX);

    // Route the selected chunk's bytes to the lanes, lane j taking byte base+j.
    always_comb begin
        for (int j = 0; j < NUM_SBOX; j++) begin
            lane_in[j] = work[base + 4'(j)];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SBOX; g++) begin : g_lane
            inv_sbox u_sbox (
                .data   (lane_in[g]),
                .result (lane_out[g])
            );
        end
    endgenerate

    // Control FSM and in-place work register update; reset wins over both handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_state;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < NUM_SBOX; j++) begin
                        work[base + 4'(j)] <= lane_out[j];
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode purely from the registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_state = work;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Self-checking bench for inv_subbytes_seq. Expected results come from
// inverting the forward AES S-box, plus the known-answer vectors.

module tb_inv_subbytes_seq;

    // Forward AES S-box; the expected inverse is found by searching it.
    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] BASIC_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] BASIC_OUT = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_busy;
    logic [127:0] d4_in_state, d4_out_state;
    logic         d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_busy;
    logic [127:0] d1_in_state, d1_out_state;
    logic         d16_in_valid, d16_in_ready, d16_out_valid, d16_out_ready, d16_busy;
    logic [127:0] d16_in_state, d16_out_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] sb4 [$];

    always #5 clk = ~clk;

    inv_subbytes_seq #(.NUM_SBOX(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_state(d4_in_state),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_state(d4_out_state),
        .busy(d4_busy)
    );

    inv_subbytes_seq #(.NUM_SBOX(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_state(d1_in_state),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_state(d1_out_state),
        .busy(d1_busy)
    );

    inv_subbytes_seq #(.NUM_SBOX(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(d16_in_valid), .in_ready(d16_in_ready), .in_state(d16_in_state),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready), .out_state(d16_out_state),
        .busy(d16_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = st[127 - 8*i -: 8];
            for (int x = 0; x < 256; x++) begin
                if (FWD[8'(x)] == b) r[127 - 8*i -: 8] = 8'(x);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] fwd(input logic [127:0] p);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = FWD[p[127 - 8*i -: 8]];
        end
        return r;
    endfunction

    task automatic pop_compare(input string tag, input logic [127:0] got);
        logic [127:0] exp;
        exp = 'x;
        if (sb4.size() > 0) exp = sb4.pop_front();
        check(tag, got, exp);
    endtask

    // Wait for the 4-lane DUT to be idle, hand it one state, push its expected result.
    task automatic send4(input string tag, input logic [127:0] st, input logic [127:0] exp);
        int guard;
        guard = 0;
        while (!d4_in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_bit({tag, "_in_ready_before"}, d4_in_ready, 1'b1);
        d4_in_valid = 1'b1;
        d4_in_state = st;
        tick();
        d4_in_valid = 1'b0;
        sb4.push_back(exp);
    endtask

    // Count cycles from the accept edge to out_valid, then consume and score.
    task automatic finish4(input string tag, input int exp_lat);
        int lat;
        logic [127:0] got;
        lat = 0;
        while (!d4_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_int({tag, "_latency"}, lat, exp_lat);
        got = d4_out_state;
        d4_out_ready = 1'b1;
        tick();
        d4_out_ready = 1'b0;
        pop_compare({tag, "_result"}, got);
        check_bit({tag, "_in_ready_after"}, d4_in_ready, 1'b1);
        check_bit({tag, "_out_valid_after"}, d4_out_valid, 1'b0);
    endtask

    initial begin
        logic [127:0] held;
        logic [127:0] p;
        logic [127:0] svec [3];
        logic [127:0] res1, res16;
        int accept_cyc [3];
        int lat, lat1, lat16, cyc, idx, got;
        logic seen;

        d4_in_valid = 0; d4_out_ready = 0; d4_in_state = '0;
        d1_in_valid = 0; d1_out_ready = 0; d1_in_state = '0;
        d16_in_valid = 0; d16_out_ready = 0; d16_in_state = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_bit("reset_in_ready", d4_in_ready, 1'b1);
        check_bit("reset_out_valid", d4_out_valid, 1'b0);
        check("reset_out_state", d4_out_state, 128'h0);
        check_bit("reset_busy", d4_busy, 1'b0);

        // Known-answer vector with in-flight status checks
        send4("basic", BASIC_IN, BASIC_OUT);
        check_bit("basic_busy_run", d4_busy, 1'b1);
        check_bit("basic_in_ready_run", d4_in_ready, 1'b0);
        check_bit("basic_out_valid_run", d4_out_valid, 1'b0);
        finish4("basic", 4);

        // Uniform byte patterns
        send4("all63", {16{8'h63}}, {16{8'h00}});
        finish4("all63", 4);
        send4("all00", {16{8'h00}}, {16{8'h52}});
        finish4("all00", 4);
        send4("all16", {16{8'h16}}, {16{8'hff}});
        finish4("all16", 4);

        // Random states built from known plaintexts through the forward S-box
        for (int i = 0; i < 3; i++) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            send4("random", fwd(p), p);
            finish4("random", 4);
        end

        // Backpressure with a stray in_valid pulse while DONE
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        send4("bp", p, model(p));
        lat = 0;
        while (!d4_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_int("bp_latency", lat, 4);
        held = d4_out_state;
        for (int i = 0; i < 5; i++) begin
            d4_in_valid = (i == 2);
            d4_in_state = ~held;
            tick();
            check_bit("bp_out_valid_hold", d4_out_valid, 1'b1);
            check("bp_out_state_stable", d4_out_state, held);
            check_bit("bp_in_ready_low", d4_in_ready, 1'b0);
        end
        d4_in_valid = 1'b0;
        d4_out_ready = 1'b1;
        tick();
        d4_out_ready = 1'b0;
        pop_compare("bp_result", held);
        check_bit("bp_in_ready_release", d4_in_ready, 1'b1);
        check_bit("bp_out_valid_release", d4_out_valid, 1'b0);
        check_bit("bp_busy_release", d4_busy, 1'b0);

        // Reset on the second RUN cycle discards the state
        d4_in_valid = 1'b1;
        d4_in_state = BASIC_IN;
        tick();
        d4_in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("midrst_in_ready", d4_in_ready, 1'b1);
        check_bit("midrst_out_valid", d4_out_valid, 1'b0);
        check("midrst_out_state", d4_out_state, 128'h0);
        check_bit("midrst_busy", d4_busy, 1'b0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (d4_out_valid) seen = 1'b1;
        end
        check_bit("midrst_no_result", seen, 1'b0);
        send4("post_rst", {16{8'h63}}, {16{8'h00}});
        finish4("post_rst", 4);

        // Back-to-back streaming with in_valid and out_ready held high
        for (int i = 0; i < 3; i++) svec[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        d4_out_ready = 1'b1;
        d4_in_valid = 1'b1;
        d4_in_state = svec[0];
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 100) begin
            if (d4_in_valid && d4_in_ready && idx < 3) begin
                accept_cyc[idx] = cyc;
                sb4.push_back(model(svec[idx]));
                idx++;
            end
            if (d4_out_valid) begin
                pop_compare("stream_result", d4_out_state);
                got++;
            end
            tick();
            cyc++;
            if (idx < 3) d4_in_state = svec[idx];
            else d4_in_valid = 1'b0;
        end
        d4_in_valid = 1'b0;
        d4_out_ready = 1'b0;
        check_int("stream_outputs", got, 3);
        check_int("stream_accepts", idx, 3);
        check_int("stream_spacing_1", accept_cyc[1] - accept_cyc[0], 6);
        check_int("stream_spacing_2", accept_cyc[2] - accept_cyc[1], 6);
        check_int("stream_sb_empty", sb4.size(), 0);

        // Lane-count sweep: 1 lane and 16 lanes on the known-answer vector
        d1_in_valid = 1'b1;
        d1_in_state = BASIC_IN;
        d16_in_valid = 1'b1;
        d16_in_state = BASIC_IN;
        check_bit("sweep1_in_ready", d1_in_ready, 1'b1);
        check_bit("sweep16_in_ready", d16_in_ready, 1'b1);
        tick();
        d1_in_valid = 1'b0;
        d16_in_valid = 1'b0;
        lat1 = -1;
        lat16 = -1;
        res1 = '0;
        res16 = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (d1_out_valid && lat1 < 0) begin
                lat1 = c;
                res1 = d1_out_state;
            end
            if (d16_out_valid && lat16 < 0) begin
                lat16 = c;
                res16 = d16_out_state;
            end
            if (lat1 >= 0 && lat16 >= 0) break;
        end
        check_int("sweep1_latency", lat1, 16);
        check_int("sweep16_latency", lat16, 1);
        check("sweep1_result", res1, BASIC_OUT);
        check("sweep16_result", res16, BASIC_OUT);
        d1_out_ready = 1'b1;
        d16_out_ready = 1'b1;
        tick();
        d1_out_ready = 1'b0;
        d16_out_ready = 1'b0;
        check_bit("sweep1_release", d1_in_ready, 1'b1);
        check_bit("sweep16_release", d16_in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
